// File: rtl/dsp_mode_ctrl_pkg.sv
// Shared display-mode definitions: mode codes, per-mode total H/V counts
// and FSM state encoding. Also used by the sync generator so the frame
// geometry is defined once.
package dsp_mode_ctrl_pkg;

    localparam int CNT_W = 11;

    localparam logic [1:0] MODE_VGA  = 2'd0;
    localparam logic [1:0] MODE_XGA  = 2'd1;
    localparam logic [1:0] MODE_SXGA = 2'd2;
    localparam logic [1:0] MODE_ILL  = 2'd3;

    // Total (active + blanking) counts per frame line / per frame
    localparam logic [CNT_W-1:0] VGA_HSC  = 11'd800;
    localparam logic [CNT_W-1:0] VGA_VSC  = 11'd525;
    localparam logic [CNT_W-1:0] XGA_HSC  = 11'd1344;
    localparam logic [CNT_W-1:0] XGA_VSC  = 11'd806;
    localparam logic [CNT_W-1:0] SXGA_HSC = 11'd1688;
    localparam logic [CNT_W-1:0] SXGA_VSC = 11'd1066;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_BLANK     = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_WAIT_FEND = 3'd4
    } state_e;

    // Horizontal total for a mode; the illegal code falls back to VGA
    function automatic logic [CNT_W-1:0] mode_hsc(input logic [1:0] mode);
        case (mode)
            MODE_XGA:  return XGA_HSC;
            MODE_SXGA: return SXGA_HSC;
            default:   return VGA_HSC;
        endcase
    endfunction

    // Vertical total for a mode; the illegal code falls back to VGA
    function automatic logic [CNT_W-1:0] mode_vsc(input logic [1:0] mode);
        case (mode)
            MODE_XGA:  return XGA_VSC;
            MODE_SXGA: return SXGA_VSC;
            default:   return VGA_VSC;
        endcase
    endfunction

endpackage

// File: rtl/dsp_frame_end.sv
// Frame-end detector: compares the sync generator counters against the
// last pixel of the active mode. The raw condition feeds the mode FSM
// directly; the registered copy is the externally visible pulse.
module dsp_frame_end
    import dsp_mode_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [CNT_W-1:0] hcnt_i,
    input  logic [CNT_W-1:0] vcnt_i,
    input  logic [1:0]       resol_i,
    input  logic             sync_rst_i,
    output logic             fe_cond_o,
    output logic             frame_end_o
);

    logic frame_end_q;
    logic frame_end_d;

    // Last-pixel match; counters are meaningless while the generator is in reset
    always_comb begin
        fe_cond_o   = (hcnt_i == (mode_hsc(resol_i) - 11'd1)) &&
                      (vcnt_i == (mode_vsc(resol_i) - 11'd1)) &&
                      !sync_rst_i;
        frame_end_d = fe_cond_o;
    end

    // One-cycle registered frame-end pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_end_q <= 1'b0;
        end else begin
            frame_end_q <= frame_end_d;
        end
    end

    assign frame_end_o = frame_end_q;

endmodule

// File: rtl/dsp_mode_ctrl.sv
// Display mode controller: accepts mode-change requests, defers the switch
// to a frame boundary (with a watchdog fallback), holds the sync generator
// in reset across the change and re-enables the display after it settles.
module dsp_mode_ctrl
    import dsp_mode_ctrl_pkg::*;
#(
    parameter int RST_CYC    = 16,
    parameter int SETTLE_FRM = 2,
    parameter int TMO_W      = 21
) (
    input  logic             DCLK,
    input  logic             DRST_X,
    input  logic             REQ_VALID,
    input  logic [1:0]       REQ_RESOL,
    output logic             REQ_READY,
    input  logic [CNT_W-1:0] HCNT,
    input  logic [CNT_W-1:0] VCNT,
    output logic [1:0]       RESOL,
    output logic             SYNC_RST,
    output logic             DISPON,
    output logic             BUSY,
    output logic             FRAME_END,
    output logic             ERR
);

    localparam int RC_W = (RST_CYC > 1)    ? $clog2(RST_CYC)    : 1;
    localparam int FC_W = (SETTLE_FRM > 1) ? $clog2(SETTLE_FRM) : 1;

    state_e           state_q,    state_d;
    logic [1:0]       resol_q,    resol_d;
    logic [1:0]       pend_q,     pend_d;
    logic             sync_rst_q, sync_rst_d;
    logic             dispon_q,   dispon_d;
    logic             ready_q,    ready_d;
    logic             busy_q,     busy_d;
    logic             err_q,      err_d;
    logic [RC_W-1:0]  rst_cnt_q,  rst_cnt_d;
    logic [FC_W-1:0]  frm_cnt_q,  frm_cnt_d;
    logic [TMO_W-1:0] wdog_q,     wdog_d;

    logic fe_cond;
    logic accept;

    dsp_frame_end u_frame_end (
        .clk_i       (DCLK),
        .rst_ni      (DRST_X),
        .hcnt_i      (HCNT),
        .vcnt_i      (VCNT),
        .resol_i     (resol_q),
        .sync_rst_i  (sync_rst_q),
        .fe_cond_o   (fe_cond),
        .frame_end_o (FRAME_END)
    );

    // Next-state and registered-output logic for the mode sequencer
    always_comb begin
        state_d    = state_q;
        resol_d    = resol_q;
        pend_d     = pend_q;
        sync_rst_d = sync_rst_q;
        dispon_d   = dispon_q;
        err_d      = 1'b0;
        rst_cnt_d  = rst_cnt_q;
        frm_cnt_d  = frm_cnt_q;
        wdog_d     = wdog_q;
        accept     = REQ_VALID && ready_q;

        case (state_q)
            ST_INIT, ST_BLANK: begin
                if (rst_cnt_q == RC_W'(RST_CYC - 1)) begin
                    state_d    = ST_SETTLE;
                    sync_rst_d = 1'b0;
                    rst_cnt_d  = '0;
                    frm_cnt_d  = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            ST_SETTLE: begin
                if (fe_cond) begin
                    if (frm_cnt_q == FC_W'(SETTLE_FRM - 1)) begin
                        state_d   = ST_RUN;
                        dispon_d  = 1'b1;
                        frm_cnt_d = '0;
                    end else begin
                        frm_cnt_d = frm_cnt_q + FC_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (REQ_RESOL == MODE_ILL) begin
                        err_d = 1'b1;
                    end else if (REQ_RESOL != resol_q) begin
                        // A frame end in this same cycle is deliberately not used:
                        // the switch waits for the next one seen in WAIT_FEND.
                        pend_d  = REQ_RESOL;
                        state_d = ST_WAIT_FEND;
                        wdog_d  = '0;
                    end
                end
            end
            ST_WAIT_FEND: begin
                if (fe_cond || (wdog_q == {TMO_W{1'b1}})) begin
                    // Switch mode only while the sync generator is forced into reset
                    state_d    = ST_BLANK;
                    resol_d    = pend_q;
                    sync_rst_d = 1'b1;
                    dispon_d   = 1'b0;
                    rst_cnt_d  = '0;
                    wdog_d     = '0;
                    err_d      = !fe_cond;
                end else begin
                    wdog_d = wdog_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        ready_d = (state_d == ST_RUN);
        busy_d  = (state_d != ST_RUN);
    end

    // State and output registers; reset discards any pending mode
    always_ff @(posedge DCLK or negedge DRST_X) begin
        if (!DRST_X) begin
            state_q    <= ST_INIT;
            resol_q    <= MODE_VGA;
            pend_q     <= MODE_VGA;
            sync_rst_q <= 1'b1;
            dispon_q   <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
            rst_cnt_q  <= '0;
            frm_cnt_q  <= '0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            resol_q    <= resol_d;
            pend_q     <= pend_d;
            sync_rst_q <= sync_rst_d;
            dispon_q   <= dispon_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            rst_cnt_q  <= rst_cnt_d;
            frm_cnt_q  <= frm_cnt_d;
            wdog_q     <= wdog_d;
        end
    end

    assign RESOL     = resol_q;
    assign SYNC_RST  = sync_rst_q;
    assign DISPON    = dispon_q;
    assign REQ_READY = ready_q;
    assign BUSY      = busy_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_dsp_mode_ctrl.sv
// Randomized self-checking bench for dsp_mode_ctrl. The sync generator is
// replaced by directly driven counters, so frame ends can be placed at will.
module tb_dsp_mode_ctrl;

    localparam int RST_CYC    = 16;
    localparam int SETTLE_FRM = 2;
    localparam int TMO_W      = 8;

    // Reference model phases
    localparam int P_HOLD   = 0;
    localparam int P_SETTLE = 1;
    localparam int P_RUN    = 2;
    localparam int P_WAIT   = 3;

    logic        DCLK      = 1'b0;
    logic        DRST_X    = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic [1:0]  REQ_RESOL = 2'd0;
    logic [10:0] HCNT      = 11'd0;
    logic [10:0] VCNT      = 11'd0;
    logic        REQ_READY;
    logic [1:0]  RESOL;
    logic        SYNC_RST;
    logic        DISPON;
    logic        BUSY;
    logic        FRAME_END;
    logic        ERR;

    int n_tests = 0;
    int n_fail  = 0;

    int H_TOT [4] = '{800, 1344, 1688, 800};
    int V_TOT [4] = '{525, 806, 1066, 525};

    int m_phase, m_resol, m_pend, m_hold, m_frames, m_wait;
    bit m_fe, m_err;

    always #5 DCLK = ~DCLK;

    dsp_mode_ctrl #(
        .RST_CYC    (RST_CYC),
        .SETTLE_FRM (SETTLE_FRM),
        .TMO_W      (TMO_W)
    ) dut (
        .DCLK      (DCLK),
        .DRST_X    (DRST_X),
        .REQ_VALID (REQ_VALID),
        .REQ_RESOL (REQ_RESOL),
        .REQ_READY (REQ_READY),
        .HCNT      (HCNT),
        .VCNT      (VCNT),
        .RESOL     (RESOL),
        .SYNC_RST  (SYNC_RST),
        .DISPON    (DISPON),
        .BUSY      (BUSY),
        .FRAME_END (FRAME_END),
        .ERR       (ERR)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = P_HOLD;
        m_resol  = 0;
        m_pend   = 0;
        m_hold   = 0;
        m_frames = 0;
        m_wait   = 0;
        m_fe     = 1'b0;
        m_err    = 1'b0;
    endtask

    // Advance the reference by one clock using the inputs held across the edge
    task automatic model_step();
        bit fe;
        bit acc;
        if (!DRST_X) begin
            model_reset();
            return;
        end
        fe  = (m_phase != P_HOLD) &&
              (int'(HCNT) == H_TOT[m_resol] - 1) &&
              (int'(VCNT) == V_TOT[m_resol] - 1);
        acc = REQ_VALID && (m_phase == P_RUN);
        m_fe  = fe;
        m_err = 1'b0;
        case (m_phase)
            P_HOLD: begin
                m_hold++;
                if (m_hold == RST_CYC) begin
                    m_phase  = P_SETTLE;
                    m_frames = 0;
                end
            end
            P_SETTLE: begin
                if (fe) begin
                    m_frames++;
                    if (m_frames == SETTLE_FRM) m_phase = P_RUN;
                end
            end
            P_RUN: begin
                if (acc) begin
                    if (REQ_RESOL == 2'd3) begin
                        m_err = 1'b1;
                    end else if (int'(REQ_RESOL) != m_resol) begin
                        m_pend  = int'(REQ_RESOL);
                        m_phase = P_WAIT;
                        m_wait  = 0;
                    end
                end
            end
            default: begin
                m_wait++;
                if (fe || m_wait == (1 << TMO_W)) begin
                    m_err   = !fe;
                    m_resol = m_pend;
                    m_phase = P_HOLD;
                    m_hold  = 0;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        chk("resol",     int'(RESOL),     m_resol);
        chk("sync_rst",  int'(SYNC_RST),  int'(m_phase == P_HOLD));
        chk("dispon",    int'(DISPON),    int'(m_phase == P_RUN || m_phase == P_WAIT));
        chk("req_ready", int'(REQ_READY), int'(m_phase == P_RUN));
        chk("busy",      int'(BUSY),      int'(m_phase != P_RUN));
        chk("frame_end", int'(FRAME_END), int'(m_fe));
        chk("err",       int'(ERR),       int'(m_err));
    endtask

    task automatic step();
        @(posedge DCLK);
        #1;
        model_step();
        check_outputs();
    endtask

    task automatic set_fe();
        HCNT = 11'(H_TOT[m_resol] - 1);
        VCNT = 11'(V_TOT[m_resol] - 1);
    endtask

    task automatic set_idle();
        HCNT      = 11'd0;
        VCNT      = 11'd0;
        REQ_VALID = 1'b0;
    endtask

    task automatic pick_inputs(input bit allow_req);
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) begin
            set_fe();
        end else if (r == 1) begin
            HCNT = 11'(H_TOT[m_resol] - 1);
            VCNT = 11'($urandom_range(0, 2047));
        end else begin
            HCNT = 11'($urandom_range(0, 2047));
            VCNT = 11'($urandom_range(0, 2047));
        end
        REQ_VALID = allow_req && ($urandom_range(0, 3) == 0);
        REQ_RESOL = 2'($urandom_range(0, 3));
    endtask

    task automatic run_to_run();
        int n;
        n = 0;
        while (m_phase != P_RUN && n < 2000) begin
            pick_inputs(1'b0);
            step();
            n++;
        end
        if (m_phase != P_RUN) chk("run_timeout", 0, 1);
        set_idle();
    endtask

    initial begin
        int n;
        int nm;
        int old;
        int errs;
        int at;

        model_reset();

        // Reset values
        #2 DRST_X = 1'b0;
        #1 check_outputs();
        repeat (3) step();
        DRST_X = 1'b1;

        // Bring-up: sync reset length, then display on at the 2nd VGA frame end
        n = 0;
        do begin
            step();
            n++;
        end while (SYNC_RST && n < 100);
        chk("bringup_sync_rst_cycles", n, RST_CYC);
        repeat (3) step();
        set_fe();
        step();
        set_idle();
        step();
        chk("bringup_dispon_after_1", int'(DISPON), 0);
        set_fe();
        step();
        set_idle();
        chk("bringup_dispon_after_2", int'(DISPON), 1);
        chk("bringup_ready", int'(REQ_READY), 1);

        // Illegal request and same-mode request in RUN
        REQ_VALID = 1'b1;
        REQ_RESOL = 2'd3;
        step();
        chk("illegal_err", int'(ERR), 1);
        REQ_RESOL = RESOL;
        step();
        REQ_VALID = 1'b0;
        chk("same_mode_err", int'(ERR), 0);
        chk("same_mode_ready", int'(REQ_READY), 1);
        step();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            pick_inputs(1'b1);
            step();
        end
        set_idle();

        // Request coincident with a frame end switches on the following one
        run_to_run();
        old = m_resol;
        nm  = (m_resol + 1) % 3;
        set_fe();
        REQ_VALID = 1'b1;
        REQ_RESOL = 2'(nm);
        step();
        set_idle();
        repeat (4) step();
        chk("coinc_resol_held", int'(RESOL), old);
        chk("coinc_dispon_held", int'(DISPON), 1);
        HCNT = 11'(H_TOT[old] - 1);
        VCNT = 11'(V_TOT[old] - 1);
        step();
        set_idle();
        chk("coinc_resol_switched", int'(RESOL), nm);
        chk("coinc_sync_rst", int'(SYNC_RST), 1);

        // Watchdog: counters frozen while waiting for a frame end
        run_to_run();
        nm = (m_resol + 2) % 3;
        REQ_VALID = 1'b1;
        REQ_RESOL = 2'(nm);
        step();
        set_idle();
        errs = 0;
        at   = -1;
        for (int i = 1; i <= (1 << TMO_W) + 4; i++) begin
            step();
            if (ERR) begin
                errs++;
                if (at < 0) at = i;
            end
        end
        chk("wdog_err_pulses", errs, 1);
        chk("wdog_err_cycle", at, 1 << TMO_W);
        chk("wdog_resol", int'(RESOL), nm);

        // Reset asserted in BLANK after an SXGA request
        run_to_run();
        if (m_resol == 2) begin
            REQ_VALID = 1'b1;
            REQ_RESOL = 2'd1;
            step();
            set_fe();
            step();
            set_idle();
            run_to_run();
        end
        REQ_VALID = 1'b1;
        REQ_RESOL = 2'd2;
        step();
        set_fe();
        step();
        set_idle();
        chk("blank_resol_sxga", int'(RESOL), 2);
        repeat (3) step();
        #2 DRST_X = 1'b0;
        #1 model_reset();
        check_outputs();
        repeat (2) step();
        DRST_X = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (SYNC_RST && n < 100);
        chk("rerst_sync_rst_cycles", n, RST_CYC);
        run_to_run();
        chk("rerst_resol_vga", int'(RESOL), 0);
        chk("rerst_dispon", int'(DISPON), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
